imem_boot_loader: RTL and testbench

//  Upstream of the single-cycle RV32 core: streams a program image byte-by-byte into

---
 rtl/imem_boot_loader_pkg.sv | 14 +
 rtl/imem_boot_loader_byte_assembler.sv | 44 ++++
 rtl/imem_boot_loader.sv | 125 ++++++++++++
 tb/tb_imem_boot_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared states and constants for the boot image loader
package imem_boot_pkg;

   typedef enum logic [2:0] {
      S_LEN  = 3'd0,
      S_DATA = 3'd1,
      S_CSUM = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_e;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_boot_loader_byte_assembler.sv
// rtl/imem_boot_loader_byte_assembler.sv - packs little-endian bytes into 32-bit words
module byte_assembler
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic [31:0] word_data,
   output logic        word_valid
);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] low_q, low_d;

   // The 4th byte is forwarded combinationally so the consumer sees the word in the accept cycle.
   assign word_valid = in_valid && (idx_q == 2'(WORD_BYTES - 1));
   assign word_data  = {in_data, low_q};

   always_comb begin
      idx_d = idx_q;
      low_d = low_q;
      if (in_valid) begin
         idx_d = idx_q + 2'd1;
         case (idx_q)
            2'd0:    low_d[7:0]   = in_data;
            2'd1:    low_d[15:8]  = in_data;
            2'd2:    low_d[23:16] = in_data;
            default: low_d        = low_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= 2'd0;
         low_q <= 24'd0;
      end else begin
         idx_q <= idx_d;
         low_q <= low_d;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length/words/checksum image into imem, then releases the core
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int          MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_reset,
   output logic        done,
   output logic        error
);

   localparam int CW = $clog2(MAX_WORDS + 1);

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] len_q, len_d;
   logic [31:0] csum_q, csum_d;
   logic        rx_ready_q, rx_ready_d;
   logic        imem_we_q, imem_we_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic [31:0] imem_wdata_q, imem_wdata_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic        done_q, done_d;
   logic        error_q, error_d;

   logic        accept;
   logic [31:0] word;
   logic        word_valid;

   assign accept = rx_valid & rx_ready_q;

   byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .in_data    (rx_data),
      .in_valid   (accept),
      .word_data  (word),
      .word_valid (word_valid)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      csum_d       = csum_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      if (word_valid) begin
         case (state_q)
            S_LEN: begin
               if (word > 32'(MAX_WORDS)) begin
                  state_d = S_ERR;
               end else if (word == 32'd0) begin
                  state_d = S_CSUM;
               end else begin
                  len_d   = word[CW-1:0];
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               imem_we_d    = 1'b1;
               imem_addr_d  = BASE_ADDR + (32'(cnt_q) << 2);
               imem_wdata_d = word;
               csum_d       = csum_q ^ word;
               cnt_d        = cnt_q + CW'(1);
               if (cnt_q == len_q - CW'(1)) state_d = S_CSUM;
            end
            S_CSUM:  state_d = (word == csum_q) ? S_DONE : S_ERR;
            default: state_d = state_q;
         endcase
      end
      // Status outputs follow the next state so they change together with the state register.
      rx_ready_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      done_d      = (state_d == S_DONE);
      error_d     = (state_d == S_ERR);
      cpu_reset_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_LEN;
         cnt_q        <= '0;
         len_q        <= '0;
         csum_q       <= 32'd0;
         rx_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= BASE_ADDR;
         imem_wdata_q <= 32'd0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         csum_q       <= csum_d;
         rx_ready_q   <= rx_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_reset_q  <= cpu_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        done;
   logic        error;

   int total = 0;
   int bad = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   localparam logic [31:0] W0   = 32'h00500093;
   localparam logic [31:0] W1   = 32'h00A00113;
   localparam logic [31:0] CSUM = 32'h00F00180;

   imem_boot_loader dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (rx_ready !== 1'b1 && t < 64) begin
         @(negedge clk);
         t++;
      end
      if (t >= 64) begin
         total++; bad++;
         $display("FAIL rx_ready_timeout got=%b exp=1", rx_ready);
      end else begin
         @(posedge clk);
      end
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic wait_end();
      int t = 0;
      while (!(done === 1'b1 || error === 1'b1) && t < 32) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic test_reset();
      rx_valid = 1'b0;
      reset    = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (rx_ready !== 1'b0)    begin bad++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
      total++; if (imem_we !== 1'b0)     begin bad++; $display("FAIL rst_imem_we got=%b exp=0", imem_we); end
      total++; if (imem_addr !== 32'h0)  begin bad++; $display("FAIL rst_imem_addr got=%h exp=0", imem_addr); end
      total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL rst_imem_wdata got=%h exp=0", imem_wdata); end
      total++; if (cpu_reset !== 1'b1)   begin bad++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
      total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      total++; if (error !== 1'b0)       begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
      reset = 1'b0;
      @(negedge clk);
      total++; if (rx_ready !== 1'b1)    begin bad++; $display("FAIL rst_ready_rise got=%b exp=1", rx_ready); end
   endtask

   task automatic test_continuous();
      do_reset();
      send_word(32'd2, 0);
      send_word(W0, 0);
      total++; if (imem_we !== 1'b1 || imem_addr !== 32'h0 || imem_wdata !== W0) begin
         bad++; $display("FAIL t1_write_timing we=%b addr=%h data=%h exp we=1 addr=0 data=%h", imem_we, imem_addr, imem_wdata, W0);
      end
      send_word(W1, 0);
      total++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin
         bad++; $display("FAIL t1_pre_csum cpu_reset=%b done=%b exp 1/0", cpu_reset, done);
      end
      send_word(CSUM, 0);
      wait_end();
      total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL t1_nwrites got=%0d exp=2", wr_addr.size()); end
      if (wr_addr.size() == 2) begin
         total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== W0) begin bad++; $display("FAIL t1_word0 got=%h@%h exp=%h@0", wr_data[0], wr_addr[0], W0); end
         total++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== W1) begin bad++; $display("FAIL t1_word1 got=%h@%h exp=%h@4", wr_data[1], wr_addr[1], W1); end
      end
      total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL t1_result done=%b error=%b exp 1/0", done, error); end
      total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL t1_cpu_reset got=%b exp=0", cpu_reset); end
      total++; if (rx_ready !== 1'b0)  begin bad++; $display("FAIL t1_rx_ready got=%b exp=0", rx_ready); end
      @(negedge clk);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      repeat (8) @(negedge clk);
      rx_valid = 1'b0;
      total++; if (wr_addr.size() != 2 || done !== 1'b1 || error !== 1'b0) begin
         bad++; $display("FAIL t1_ignore_after_done nwrites=%0d done=%b error=%b exp 2/1/0", wr_addr.size(), done, error);
      end
   endtask

   task automatic test_toggled();
      do_reset();
      send_word(32'd2, 1);
      send_word(W0, 1);
      send_word(W1, 1);
      send_word(CSUM, 1);
      wait_end();
      total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL t2_nwrites got=%0d exp=2", wr_addr.size()); end
      if (wr_addr.size() == 2) begin
         total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== W0) begin bad++; $display("FAIL t2_word0 got=%h@%h exp=%h@0", wr_data[0], wr_addr[0], W0); end
         total++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== W1) begin bad++; $display("FAIL t2_word1 got=%h@%h exp=%h@4", wr_data[1], wr_addr[1], W1); end
      end
      total++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin bad++; $display("FAIL t2_result done=%b cpu_reset=%b exp 1/0", done, cpu_reset); end
   endtask

   task automatic test_bad_csum();
      do_reset();
      send_word(32'd1, 0);
      send_word(32'h12345678, 0);
      send_word(32'h12345679, 0);
      wait_end();
      total++; if (wr_addr.size() != 1) begin bad++; $display("FAIL t3_nwrites got=%0d exp=1", wr_addr.size()); end
      if (wr_addr.size() == 1) begin
         total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h12345678) begin bad++; $display("FAIL t3_word0 got=%h@%h exp=12345678@0", wr_data[0], wr_addr[0]); end
      end
      total++; if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL t3_result error=%b done=%b exp 1/0", error, done); end
      total++; if (cpu_reset !== 1'b1 || rx_ready !== 1'b0) begin bad++; $display("FAIL t3_hold cpu_reset=%b rx_ready=%b exp 1/0", cpu_reset, rx_ready); end
   endtask

   task automatic test_overflow();
      do_reset();
      send_word(32'h401, 0);
      wait_end();
      total++; if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL t4_result error=%b done=%b exp 1/0", error, done); end
      total++; if (rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin bad++; $display("FAIL t4_hold rx_ready=%b cpu_reset=%b exp 0/1", rx_ready, cpu_reset); end
      @(negedge clk);
      rx_data  = 8'h01;
      rx_valid = 1'b1;
      repeat (12) @(negedge clk);
      rx_valid = 1'b0;
      total++; if (wr_addr.size() != 0 || error !== 1'b1) begin bad++; $display("FAIL t4_no_write nwrites=%0d error=%b exp 0/1", wr_addr.size(), error); end
   endtask

   task automatic test_empty();
      do_reset();
      send_word(32'd0, 0);
      send_word(32'd0, 0);
      wait_end();
      total++; if (done !== 1'b1 || error !== 1'b0 || wr_addr.size() != 0) begin
         bad++; $display("FAIL t5_empty_ok done=%b error=%b nwrites=%0d exp 1/0/0", done, error, wr_addr.size());
      end
      do_reset();
      send_word(32'd0, 0);
      send_word(32'd1, 0);
      wait_end();
      total++; if (error !== 1'b1 || done !== 1'b0 || wr_addr.size() != 0) begin
         bad++; $display("FAIL t5_empty_bad error=%b done=%b nwrites=%0d exp 1/0/0", error, done, wr_addr.size());
      end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      send_word(32'd2, 0);
      send_word(W0, 0);
      send_byte(W1[7:0], 0);
      send_byte(W1[15:8], 0);
      total++; if (wr_addr.size() != 1 || cpu_reset !== 1'b1) begin
         bad++; $display("FAIL t6_partial nwrites=%0d cpu_reset=%b exp 1/1", wr_addr.size(), cpu_reset);
      end
      do_reset();
      total++; if (cpu_reset !== 1'b1 || done !== 1'b0 || imem_addr !== 32'h0) begin
         bad++; $display("FAIL t6_after_reset cpu_reset=%b done=%b addr=%h exp 1/0/0", cpu_reset, done, imem_addr);
      end
      send_word(32'd2, 0);
      send_word(W0, 0);
      send_word(W1, 0);
      total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL t6_cpu_held got=%b exp=1", cpu_reset); end
      send_word(CSUM, 0);
      wait_end();
      total++; if (wr_addr.size() != 2) begin bad++; $display("FAIL t6_nwrites got=%0d exp=2", wr_addr.size()); end
      if (wr_addr.size() == 2) begin
         total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== W0) begin bad++; $display("FAIL t6_word0 got=%h@%h exp=%h@0", wr_data[0], wr_addr[0], W0); end
         total++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== W1) begin bad++; $display("FAIL t6_word1 got=%h@%h exp=%h@4", wr_data[1], wr_addr[1], W1); end
      end
      total++; if (done !== 1'b1 || error !== 1'b0 || cpu_reset !== 1'b0) begin
         bad++; $display("FAIL t6_result done=%b error=%b cpu_reset=%b exp 1/0/0", done, error, cpu_reset);
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_toggled();
      test_bad_csum();
      test_overflow();
      test_empty();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
